// File: rtl/vli_encoder_pkg.sv
// Shared constants and types for the JPEG VLI encode path.
package vli_encoder_pkg;

    localparam int unsigned VLI_COEF_W   = 12;
    localparam int unsigned VLI_SIZE_W   = 4;
    localparam int unsigned VLI_SYM_W    = 11;
    localparam int unsigned VLI_MAX_SIZE = 11;

    // Category plus additional bits, as consumed by the bit packer.
    typedef struct packed {
        logic [3:0]  size;
        logic [10:0] symbol;
    } vli_sym_t;

    // Mirror an 11-bit field so the code MSB lands in bit 0.
    function automatic logic [10:0] bit_reverse(input logic [10:0] x);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) begin
            r[i] = x[10 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vli_size_calc.sv
// Leading-one detect: JPEG size category of an 11-bit magnitude.
module vli_size_calc
    import vli_encoder_pkg::*;
(
    input  logic [VLI_SYM_W-1:0]  magnitude,
    output logic [VLI_SIZE_W-1:0] size
);

    // Highest set bit wins; zero magnitude gives category 0.
    always_comb begin
        size = '0;
        for (int i = 0; i < int'(VLI_SYM_W); i++) begin
            if (magnitude[i]) begin
                size = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/vli_encoder.sv
// Two-stage streaming VLI encoder: coefficient in, (size, symbol) out.
module vli_encoder
    import vli_encoder_pkg::*;
#(
    parameter int unsigned COEF_W = VLI_COEF_W,
    parameter int unsigned SIZE_W = VLI_SIZE_W,
    parameter int unsigned SYM_W  = VLI_SYM_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE_W-1:0] out_size,
    output logic [SYM_W-1:0]  out_symbol,
    output logic              out_clamped
);

    logic             a_valid;
    logic             a_neg;
    logic [SYM_W-1:0] a_mag;
    logic             a_clamp;

    logic             b_valid;
    vli_sym_t         b_sym;
    logic             b_clamped;

    logic             a_adv;
    logic             b_adv;
    logic             accept;

    logic             neg_in;
    logic             clamp_in;
    logic [SYM_W-1:0] mag_in;

    logic [SIZE_W-1:0] size_d;
    logic [SYM_W-1:0]  mask_d;
    logic [SYM_W-1:0]  code_d;
    vli_sym_t          sym_d;

    assign b_adv    = !b_valid || out_ready;
    assign a_adv    = !a_valid || b_adv;
    assign in_ready = a_adv && !clear;
    assign accept   = in_valid && in_ready;

    // Stage A input decode: sign, magnitude, and clamp of the one unencodable value.
    always_comb begin
        neg_in   = in_value[COEF_W-1];
        clamp_in = (in_value == {1'b1, {(COEF_W-1){1'b0}}});
        if (clamp_in) begin
            mag_in = '1;
        end else if (neg_in) begin
            mag_in = ~in_value[SYM_W-1:0] + 1'b1;
        end else begin
            mag_in = in_value[SYM_W-1:0];
        end
    end

    vli_size_calc u_size_calc (
        .magnitude (a_mag),
        .size      (size_d)
    );

    // Stage B encode: negative values send the ones-complement, then MSB-first reorder.
    always_comb begin
        mask_d        = ~({SYM_W{1'b1}} << size_d);
        code_d        = a_neg ? (~a_mag & mask_d) : a_mag;
        sym_d.size    = size_d;
        sym_d.symbol  = bit_reverse(code_d) >> (SYM_W - size_d);
    end

    // Stage A registers; clear drops the valid bit but leaves payload stale.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_neg   <= 1'b0;
            a_mag   <= '0;
            a_clamp <= 1'b0;
        end else begin
            if (clear) begin
                a_valid <= 1'b0;
            end else if (a_adv) begin
                a_valid <= accept;
            end
            if (accept) begin
                a_neg   <= neg_in;
                a_mag   <= mag_in;
                a_clamp <= clamp_in;
            end
        end
    end

    // Stage B registers drive the outputs; payload only moves when B advances.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_valid   <= 1'b0;
            b_sym     <= '0;
            b_clamped <= 1'b0;
        end else begin
            if (clear) begin
                b_valid <= 1'b0;
            end else if (b_adv) begin
                b_valid <= a_valid;
            end
            if (b_adv && a_valid && !clear) begin
                b_sym     <= sym_d;
                b_clamped <= a_clamp;
            end
        end
    end

    assign out_valid   = b_valid;
    assign out_size    = b_sym.size;
    assign out_symbol  = b_sym.symbol;
    assign out_clamped = b_clamped;

endmodule
